if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  branch taken; discard all queued entries and any same-cycle push or pop.
REQ-005 in_valid  input  1  fetch stage presents a PC/instruction pair this cycle.
REQ-006 in_pc  input  32  fetch-stage PC (already +4).
REQ-007 in_instruction  input  32  fetched instruction word.
REQ-008 freeze_if  output  1  fetch-stage freeze; high when the queue is full.
REQ-009 out_ready  input  1  decode stage accepts the head entry this cycle (low on hazard stall).
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_pc  output  32  head entry PC.
REQ-012 out_instruction  output  32  head entry instruction.
REQ-013 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Storage: DEPTH entries of {pc, instruction}, 64 bits each; read pointer, write pointer and count are registers.
REQ-015 Push: occurs when in_valid=1, count<DEPTH and flush=0; entry written at write pointer on that clk edge; write pointer advances modulo DEPTH.
REQ-016 Push attempted while count=DEPTH is dropped; fetch stage retries because freeze_if holds its PC.
REQ-017 Pop: occurs when out_valid=1, out_ready=1 and flush=0; read pointer advances modulo DEPTH.
REQ-018 Simultaneous push and pop: both occur; count unchanged.
REQ-019 Push into an empty queue appears at the outputs on the next cycle, never the same cycle (1-cycle latency, no bypass).
REQ-020 out_valid = (count != 0); out_pc/out_instruction drive the head entry when valid, 32'd0 (NOP bubble) when empty.
REQ-021 freeze_if = (count == DEPTH), decoded from registered count only; no combinational path from any input.
REQ-022 Full-and-pop cycle: freeze_if stays high that cycle; the push slot frees on the following cycle.
REQ-023 Pointer wrap-around: DEPTH-1 advances to 0 with no bubble or reordering; strict FIFO order.
REQ-024 Flush: on the clk edge with flush=1, count, read and write pointers clear to 0; next cycle out_valid=0, freeze_if=0.
REQ-025 flush=1 concurrent with in_valid=1 discards the incoming pair (wrong-path fetch).
REQ-026 Storage contents need not be cleared; out_valid gating alone hides stale data.

Reset
REQ-027 rst=1 at a clk edge: pointers and count to 0; out_valid=0, out_pc=0, out_instruction=0, freeze_if=0.
REQ-028 rst overrides flush, push and pop in the same cycle; a reset mid-operation discards all entries.
REQ-029 No asynchronous reset path; storage array is not reset.

Structure
REQ-030 Shared package holds: default DEPTH constant, NOP_INSTR = 32'd0, ENTRY_W = 64.
REQ-031 Single module with no sub-modules; storage, pointers and count inline.
REQ-032 Pointer width clog2(DEPTH); count width one bit wider.

Verification
REQ-033 Reset then push pc=4/0xE3A00001, out_ready=0 -> next cycle out_valid=1, out_pc=4, out_instruction=0xE3A00001, count=1.
REQ-034 Push 4 entries, out_ready=0 -> count=4, freeze_if=1; 5th push (pc=20) dropped; drain yields pc 4,8,12,16 in order.
REQ-035 Count=2, push and pop same cycle -> count stays 2; head advances to the next PC.
REQ-036 Count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_instruction=0, freeze_if=0.
REQ-037 Ten push/pop pairs at count=1 -> pointers wrap twice; output PC sequence strictly increasing by 4.
REQ-038 rst=1 with flush=1, in_valid=1 and count=4 -> next cycle all outputs 0, count=0.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants and entry layout for the IF/ID decoupling queue.
package if_id_queue_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned ENTRY_W       = 64;
  localparam logic [31:0] NOP_INSTR     = 32'd0;

  // One queued fetch result: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } entry_t;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue.sv
// IF/ID queue: small FIFO of {pc, instruction} pairs between fetch and decode.
// Registered outputs only drive freeze_if; the head is read from storage with
// no bypass, so a push into an empty queue is visible one cycle later.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instruction,
  output logic                     freeze_if,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push;
  logic               pop;
  logic               full;
  entry_t             head;

  // Handshake decode; flush suppresses both sides of the transfer.
  always_comb begin
    full      = (count_q == FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && !full && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array is never cleared; out_valid gating hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= '{pc: in_pc, instruction: in_instruction};
    end
  end

  // Head presentation: NOP bubble when empty, freeze from registered count only.
  always_comb begin
    head            = mem[rd_ptr_q];
    out_pc          = out_valid ? head.pc          : NOP_INSTR;
    out_instruction = out_valid ? head.instruction : NOP_INSTR;
    freeze_if       = full;
    count           = count_q;
  end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH = 4).
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic        freeze_if;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instruction (in_instruction),
    .freeze_if      (freeze_if),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instruction(out_instruction),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hE3A0, pc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instruction = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pc = base + 32'(4 * i);
      in_instruction = instr_of(in_pc);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (out_instruction !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instruction); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b exp 0", freeze_if); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_single_push();
    do_reset();
    in_valid = 1'b1; in_pc = 32'd4; in_instruction = 32'hE3A00001; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push_valid got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'd4) begin errors++; $display("FAIL push_pc got %h exp 4", out_pc); end
    checks++; if (out_instruction !== 32'hE3A00001) begin errors++; $display("FAIL push_instr got %h exp e3a00001", out_instruction); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL push_count got %0d exp 1", count); end
  endtask

  task automatic test_full();
    do_reset();
    fill(4, 32'd4);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (freeze_if !== 1'b1) begin errors++; $display("FAIL full_freeze got %b exp 1", freeze_if); end
    in_valid = 1'b1; in_pc = 32'd20; in_instruction = instr_of(32'd20);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", count); end
    out_ready = 1'b1;
    #1;
    checks++; if (freeze_if !== 1'b1) begin errors++; $display("FAIL full_pop_freeze got %b exp 1", freeze_if); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== 32'(4 + 4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %0d exp %0d", i, out_pc, 4 + 4 * i); end
      checks++; if (out_instruction !== instr_of(32'(4 + 4 * i))) begin errors++; $display("FAIL drain_instr[%0d] got %h exp %h", i, out_instruction, instr_of(32'(4 + 4 * i))); end
      step();
      if (i == 0) begin
        checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL freeze_release got %b exp 0", freeze_if); end
      end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count got %0d exp 0", count); end
  endtask

  task automatic test_push_pop();
    do_reset();
    fill(2, 32'd4);
    in_valid = 1'b1; in_pc = 32'd12; in_instruction = instr_of(32'd12); out_ready = 1'b1;
    #1;
    checks++; if (out_pc !== 32'd4) begin errors++; $display("FAIL pp_head_before got %0d exp 4", out_pc); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count got %0d exp 2", count); end
    checks++; if (out_pc !== 32'd8) begin errors++; $display("FAIL pp_head_after got %0d exp 8", out_pc); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'd12) begin errors++; $display("FAIL pp_tail got %0d exp 12", out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    fill(3, 32'd4);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'd99; in_instruction = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (out_instruction !== 32'd0) begin errors++; $display("FAIL flush_instr got %h exp 0", out_instruction); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL flush_pc got %h exp 0", out_pc); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL flush_freeze got %b exp 0", freeze_if); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_hold got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    fill(1, 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'(8 + 4 * i); in_instruction = instr_of(in_pc); out_ready = 1'b1;
      #1;
      checks++; if (out_pc !== 32'(4 + 4 * i)) begin errors++; $display("FAIL wrap_pc[%0d] got %0d exp %0d", i, out_pc, 4 + 4 * i); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", count); end
    checks++; if (out_pc !== 32'd44) begin errors++; $display("FAIL wrap_last_pc got %0d exp 44", out_pc); end
    checks++; if (out_instruction !== instr_of(32'd44)) begin errors++; $display("FAIL wrap_last_instr got %h exp %h", out_instruction, instr_of(32'd44)); end
  endtask

  task automatic test_reset_override();
    do_reset();
    fill(4, 32'd100);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'd200; in_instruction = 32'h12345678; out_ready = 1'b1;
    step();
    idle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_ovr_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovr_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_ovr_pc got %h exp 0", out_pc); end
    checks++; if (out_instruction !== 32'd0) begin errors++; $display("FAIL rst_ovr_instr got %h exp 0", out_instruction); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL rst_ovr_freeze got %b exp 0", freeze_if); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_push();
    test_full();
    test_push_pop();
    test_flush();
    test_wrap();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_id_queue
